addmul_share_ctrl: RTL and testbench

Arbitration and sequencing controller that shares one 2-stage add/sub-multiply datapath, d = (s ? a+b : a-b)*c, between two requesters. Round-robin grant with valid/ready handshake on each request port. Result port has valid/ready with backpressure. Drives per-stage clock-gate enables so that idle stages, and stages whose result is known to be zero, do not toggle.

---
 rtl/addmul_share_ctrl_if.sv | 42 ++++
 rtl/addmul_share_ctrl.sv | 136 +++++++++++++
 tb/tb_addmul_share_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/addmul_share_ctrl_if.sv
// rtl/addmul_share_ctrl_if.sv - request/result handshake bundle for addmul_share_ctrl
interface addmul_share_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 1
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_W-1:0]     req0_a;
  logic [DATA_W-1:0]     req0_b;
  logic [DATA_W-1:0]     req0_c;
  logic                  req0_s;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_W-1:0]     req1_a;
  logic [DATA_W-1:0]     req1_b;
  logic [DATA_W-1:0]     req1_c;
  logic                  req1_s;

  logic                  res_valid;
  logic                  res_ready;
  logic [2*DATA_W-1:0]   res_d;
  logic [ID_W-1:0]       res_id;

  // Requesters and result consumer
  modport master (
    output req0_valid, req0_a, req0_b, req0_c, req0_s,
    output req1_valid, req1_a, req1_b, req1_c, req1_s,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_d, res_id
  );

  // Shared datapath controller
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c, req0_s,
    input  req1_valid, req1_a, req1_b, req1_c, req1_s,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_d, res_id
  );
endinterface

// File: rtl/addmul_share_ctrl.sv
// rtl/addmul_share_ctrl.sv - two-requester round-robin controller for a 2-stage (a+/-b)*c datapath
// Optional macro ADDMUL_ZERO_SKIP_EN: skip the product register load for ops with c==0.
module addmul_share_ctrl #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  addmul_share_ctrl_if.slave   bus,
  output logic                 st1_cg_en,
  output logic                 st2_cg_en
);

  // Pipeline valid flags and round-robin pointer (never gated)
  logic                 v1, v2;
  logic                 ptr;

  // Stage-1 data
  logic [DATA_W:0]      s1_sum;
  logic [DATA_W-1:0]    s1_c;
  logic [ID_W-1:0]      s1_id;

  // Stage-2 data
  logic [2*DATA_W-1:0]  s2_prod;
  logic [ID_W-1:0]      s2_id;

  // Handshake / control nets
  logic                 s2_load, accept_ok, grant0, grant1, accept, s1_clear;
  logic                 s2_data_en, s2_take;
  logic [DATA_W-1:0]    op_a, op_b, op_c;
  logic                 op_s;
  logic [DATA_W:0]      op_sum;
  logic [2*DATA_W-1:0]  ext_sum, ext_c, prod;

`ifdef ADDMUL_ZERO_SKIP_EN
  logic                 s1_zero, s2_zero;
`endif

  // Arbitration, stage advance and clock-gate enables
  always_comb begin
    s2_load   = ~v2 | bus.res_ready;
    accept_ok = ~rst & (~v1 | s2_load);
    grant0    = accept_ok & bus.req0_valid & (~bus.req1_valid | ~ptr);
    grant1    = accept_ok & bus.req1_valid & (~bus.req0_valid |  ptr);
    accept    = grant0 | grant1;
    s1_clear  = ~rst & v1 & s2_load & ~accept;
    s2_take   = ~rst & s2_load & v1;
`ifdef ADDMUL_ZERO_SKIP_EN
    s2_data_en = s2_take & ~s1_zero;
`else
    s2_data_en = s2_take;
`endif
    st1_cg_en = accept | s1_clear;
    st2_cg_en = s2_data_en;

    op_a   = grant1 ? bus.req1_a : bus.req0_a;
    op_b   = grant1 ? bus.req1_b : bus.req0_b;
    op_c   = grant1 ? bus.req1_c : bus.req0_c;
    op_s   = grant1 ? bus.req1_s : bus.req0_s;
    op_sum = op_s ? ({1'b0, op_a} + {1'b0, op_b}) : ({1'b0, op_a} - {1'b0, op_b});

    ext_sum = {{(DATA_W-1){1'b0}}, s1_sum};
    ext_c   = {{DATA_W{1'b0}}, s1_c};
    prod    = ext_sum * ext_c;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.res_valid  = v2;
  assign bus.res_id     = s2_id;
`ifdef ADDMUL_ZERO_SKIP_EN
  assign bus.res_d      = s2_zero ? '0 : s2_prod;
`else
  assign bus.res_d      = s2_prod;
`endif

  // Valid flags, zero flags and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      ptr <= 1'b0;
`ifdef ADDMUL_ZERO_SKIP_EN
      s1_zero <= 1'b0;
      s2_zero <= 1'b0;
`endif
    end else begin
      if (accept)
        v1 <= 1'b1;
      else if (s2_load)
        v1 <= 1'b0;
      if (s2_load)
        v2 <= v1;
      if (grant0)
        ptr <= 1'b1;
      else if (grant1)
        ptr <= 1'b0;
`ifdef ADDMUL_ZERO_SKIP_EN
      if (accept)
        s1_zero <= (op_c == '0);
      if (s2_take)
        s2_zero <= s1_zero;
`endif
    end
  end

  // Stage-1 operand registers load only on an accepted op
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sum <= '0;
      s1_c   <= '0;
      s1_id  <= '0;
    end else if (accept) begin
      s1_sum <= op_sum;
      s1_c   <= op_c;
      s1_id  <= ID_W'(grant1);
    end
  end

  // Stage-2 tag follows every op that moves out of stage 1
  always_ff @(posedge clk) begin
    if (rst)
      s2_id <= '0;
    else if (s2_take)
      s2_id <= s1_id;
  end

  // Stage-2 product register; held when the op is known to produce zero
  always_ff @(posedge clk) begin
    if (rst)
      s2_prod <= '0;
    else if (s2_data_en)
      s2_prod <= prod;
  end

endmodule

// File: tb/tb_addmul_share_ctrl.sv
// tb/tb_addmul_share_ctrl.sv - directed self-checking bench for addmul_share_ctrl
module tb_addmul_share_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic st1_cg_en, st2_cg_en;

  always #5 clk = ~clk;

  addmul_share_ctrl_if #(.DATA_W(8), .ID_W(1)) bus ();

  addmul_share_ctrl #(.DATA_W(8), .ID_W(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .st1_cg_en (st1_cg_en),
    .st2_cg_en (st2_cg_en)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        s;
    logic [15:0] d;
  } vec_t;

  vec_t        vecs [8];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          zero_skip;
  logic [15:0] exp_d_q [$];
  int          exp_id_q [$];
  int          cur_k [2];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_d(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input bit s);
    int unsigned t;
    t = s ? (a + b) : (a - b);
    return 16'(t * c);
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_c = '0; bus.req0_s = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_c = '0; bus.req1_s = 1'b0;
    bus.res_ready  = 1'b1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic s);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_c = c; bus.req0_s = s;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_c = c; bus.req1_s = s;
    end
  endtask

  task automatic set_k(input int id, input int k);
    cur_k[id] = k;
    set_req(id, 1'b1, 8'(20 + k), 8'(k), 8'(k + 1), k[0]);
  endtask

  // Starts and ends at posedge+1
  task automatic run_single(input int id, input vec_t v, input bit exp_cg2);
    set_req(id, 1'b1, v.a, v.b, v.c, v.s);
    @(negedge clk);
    chk("single_ready", (id == 0) ? bus.req0_ready : bus.req1_ready, 1);
    @(posedge clk); #1;
    set_req(id, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    chk("single_valid_early", bus.res_valid, 0);
    chk("single_st2_cg", st2_cg_en, exp_cg2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_valid", bus.res_valid, 1);
    chk("single_d", bus.res_d, v.d);
    chk("single_id", bus.res_id, id);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_drained", bus.res_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_grant, n_res, exp_g, gid, next_k;
    logic g0, g1;

`ifdef ADDMUL_ZERO_SKIP_EN
    zero_skip = 1'b1;
`else
    zero_skip = 1'b0;
`endif

    vecs[0] = '{8'd10,  8'd3,   8'd4,   1'b1, 16'd52};
    vecs[1] = '{8'd200, 8'd50,  8'd3,   1'b0, 16'd450};
    vecs[2] = '{8'd255, 8'd255, 8'd255, 1'b1, 16'd64514};
    vecs[3] = '{8'd5,   8'd5,   8'd0,   1'b1, 16'd0};
    vecs[4] = '{8'd100, 8'd100, 8'd9,   1'b0, 16'd0};
    vecs[5] = '{8'd128, 8'd127, 8'd200, 1'b1, 16'd51000};
    vecs[6] = '{8'd255, 8'd1,   8'd255, 1'b0, 16'd64770};
    vecs[7] = '{8'd1,   8'd1,   8'd1,   1'b1, 16'd2};

    // Reset state, with requests pending so ready gating is exercised
    idle_inputs();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_d", bus.res_d, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_st1_cg", st1_cg_en, 0);
    chk("rst_st2_cg", st2_cg_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    // Single ops from the vector table, alternating requesters
    for (int i = 0; i < 8; i++)
      run_single(i % 2, vecs[i], !(zero_skip && vecs[i].c == 8'd0));

    // Backpressure: A, B accepted; C held off while both stages full
    set_req(0, 1'b1, 8'd10, 8'd3, 8'd4, 1'b1);
    @(negedge clk);
    chk("bp_ready_a", bus.req0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 1'b1, 8'd9, 8'd4, 8'd7, 1'b0);
    @(negedge clk);
    chk("bp_ready_b", bus.req0_ready, 1);
    chk("bp_valid_early", bus.res_valid, 0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 8'd12, 8'd12, 8'd100, 1'b1);
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stall_valid", bus.res_valid, 1);
      chk("bp_stall_d", bus.res_d, 52);
      chk("bp_stall_id", bus.res_id, 0);
      chk("bp_stall_ready", bus.req0_ready, 0);
      chk("bp_stall_st1_cg", st1_cg_en, 0);
      chk("bp_stall_st2_cg", st2_cg_en, 0);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready_c", bus.req0_ready, 1);
    chk("bp_resume_d_a", bus.res_d, 52);
    chk("bp_resume_st1_cg", st1_cg_en, 1);
    chk("bp_resume_st2_cg", st2_cg_en, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    chk("bp_valid_b", bus.res_valid, 1);
    chk("bp_d_b", bus.res_d, 35);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_c", bus.res_valid, 1);
    chk("bp_d_c", bus.res_d, 2400);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", bus.res_valid, 0);
    @(posedge clk); #1;

    // Idle gating
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_st1_cg", st1_cg_en, 0);
      chk("idle_st2_cg", st2_cg_en, 0);
      @(posedge clk); #1;
    end

    // Contention from a fresh reset: grants alternate starting at requester 0
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_k(0, 0);
    set_k(1, 1);
    next_k  = 2;
    n_grant = 0;
    n_res   = 0;
    exp_g   = 0;
    for (int cyc = 0; cyc < 60 && n_res < 20; cyc++) begin
      @(negedge clk);
      g0  = bus.req0_ready;
      g1  = bus.req1_ready;
      gid = -1;
      if (g0 || g1) begin
        chk("cont_one_grant", {31'd0, g0 & g1}, 0);
        gid = g1 ? 1 : 0;
        chk("cont_rr", gid, exp_g);
        exp_g ^= 1;
        exp_d_q.push_back(ref_d(20 + cur_k[gid], cur_k[gid], cur_k[gid] + 1, cur_k[gid] % 2 == 1));
        exp_id_q.push_back(gid);
        n_grant++;
      end
      if (n_res > 0 && n_res < 20)
        chk("cont_no_bubble", bus.res_valid, 1);
      if (bus.res_valid === 1'b1) begin
        if (exp_d_q.size() == 0) begin
          chk("cont_unexpected_result", bus.res_valid, 0);
        end else begin
          chk("cont_d", bus.res_d, exp_d_q.pop_front());
          chk("cont_id", bus.res_id, exp_id_q.pop_front());
        end
        n_res++;
      end
      @(posedge clk); #1;
      if (n_grant >= 20) begin
        set_req(0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        set_req(1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
      end else if (gid >= 0) begin
        set_k(gid, next_k);
        next_k++;
      end
    end
    chk("cont_results", n_res, 20);
    chk("cont_grants", n_grant, 20);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-flight: two ops from requester 0 leave the pointer at 1
    set_req(0, 1'b1, 8'd10, 8'd3, 8'd4, 1'b1);
    @(negedge clk);
    chk("mid_ready_1", bus.req0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 1'b1, 8'd200, 8'd50, 8'd3, 1'b0);
    @(negedge clk);
    chk("mid_ready_2", bus.req0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_stale", bus.res_valid, 0);
      @(posedge clk); #1;
    end
    set_req(0, 1'b1, 8'd7, 8'd2, 8'd6, 1'b1);
    set_req(1, 1'b1, 8'd9, 8'd1, 8'd2, 1'b0);
    @(negedge clk);
    chk("mid_ptr_ready0", bus.req0_ready, 1);
    chk("mid_ptr_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    set_req(1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_new_valid", bus.res_valid, 1);
    chk("mid_new_d", bus.res_d, 54);
    chk("mid_new_id", bus.res_id, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_drained", bus.res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
